pia_port: RTL and testbench

One peripheral side of the 6520 PIA: the register file and control logic that holds the output register (OR), data direction register (DDR) and control register (CR). It drives `outreg`/`ddr` into the per-pin tristate interface buffer directly downstream and takes that buffer's input-direction pin values back for CPU reads. It also runs the C1/C2 control lines: edge-detected interrupt flags, handshake and pulse output modes, and the active-low IRQ.

---
 rtl/pia_pkg.sv | 19 +
 rtl/pia_edge_det.sv | 30 +++
 rtl/pia_port.sv | 113 +++++++++++
 tb/tb_pia_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pia_pkg.sv
// Shared constants for the PIA peripheral port: control register bit positions
// and the C2 output-mode encodings held in CR[5:3].
package pia_pkg;

    localparam int CR_C1_EN   = 0;
    localparam int CR_C1_EDGE = 1;
    localparam int CR_OR_SEL  = 2;
    localparam int CR_C2_EN   = 3;
    localparam int CR_C2_EDGE = 4;
    localparam int CR_C2_OUT  = 5;
    localparam int CR_IRQ2    = 6;
    localparam int CR_IRQ1    = 7;

    localparam logic [2:0] C2_HANDSHAKE = 3'b100;
    localparam logic [2:0] C2_PULSE     = 3'b101;
    localparam logic [2:0] C2_MAN_LO    = 3'b110;
    localparam logic [2:0] C2_MAN_HI    = 3'b111;

endpackage

// File: rtl/pia_edge_det.sv
// Synchronises an asynchronous control pin and flags one active edge,
// where the active polarity is selected by rise (1 = rising, 0 = falling).
module pia_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic rise,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic hist;

    // All flops reset high so an idle-high pin produces no edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign evt = rise ? (sync2 & ~hist) : (~sync2 & hist);

endmodule

// File: rtl/pia_port.sv
// One peripheral side of a 6520 PIA: OR/DDR/CR register file, C1/C2 edge
// flags, C2 handshake/pulse/manual output and the active-low IRQ.
module pia_port
    import pia_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] dbin,
    output logic [7:0] dbout,
    input  logic [7:0] pinin,
    output logic [7:0] outreg,
    output logic [7:0] ddr,
    input  logic       c1,
    input  logic       c2_in,
    output logic       c2_out,
    output logic       c2_oe,
    output logic       irq_n
);

    logic [7:0] cr;
    logic [2:0] c2_mode;
    logic       wr_en;
    logic       rd_en;
    logic       or_rd;
    logic       or_rd_q;
    logic       c1_evt;
    logic       c1_evt_q;
    logic       c2_evt;
    logic [7:0] pin_rd;

    assign c2_mode = cr[5:3];
    assign wr_en   = cs & ~rw;
    assign rd_en   = cs & rw;
    assign or_rd   = rd_en & ~rs & cr[CR_OR_SEL];
    assign pin_rd  = (ddr & outreg) | (~ddr & pinin);

    pia_edge_det u_c1_det (
        .clk  (clk),
        .rst  (rst),
        .din  (c1),
        .rise (cr[CR_C1_EDGE]),
        .evt  (c1_evt)
    );

    pia_edge_det u_c2_det (
        .clk  (clk),
        .rst  (rst),
        .din  (c2_in),
        .rise (cr[CR_C2_EDGE]),
        .evt  (c2_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outreg   <= 8'h00;
            ddr      <= 8'h00;
            cr       <= 8'h00;
            dbout    <= 8'h00;
            or_rd_q  <= 1'b0;
            c1_evt_q <= 1'b0;
            c2_out   <= 1'b1;
        end else begin
            if (wr_en) begin
                if (rs)
                    cr[5:0] <= dbin[5:0];
                else if (cr[CR_OR_SEL])
                    outreg <= dbin;
                else
                    ddr <= dbin;
            end

            // A flag set in the same cycle as an OR read survives the clear.
            if (c1_evt)
                cr[CR_IRQ1] <= 1'b1;
            else if (or_rd)
                cr[CR_IRQ1] <= 1'b0;

            if (c2_evt && !cr[CR_C2_OUT])
                cr[CR_IRQ2] <= 1'b1;
            else if (or_rd)
                cr[CR_IRQ2] <= 1'b0;

            // Read data captures the flags before this cycle's clear takes effect.
            if (rd_en)
                dbout <= rs ? cr : (cr[CR_OR_SEL] ? pin_rd : ddr);

            // C2 reacts one cycle after the OR read / C1 event that triggers it.
            or_rd_q  <= or_rd;
            c1_evt_q <= c1_evt;

            case (c2_mode)
                C2_HANDSHAKE: begin
                    if (c1_evt_q)
                        c2_out <= 1'b1;
                    else if (or_rd_q)
                        c2_out <= 1'b0;
                end
                C2_PULSE:  c2_out <= ~or_rd_q;
                C2_MAN_LO: c2_out <= 1'b0;
                C2_MAN_HI: c2_out <= 1'b1;
                default:   c2_out <= 1'b1;
            endcase
        end
    end

    assign c2_oe = cr[CR_C2_OUT];
    assign irq_n = ~((cr[CR_IRQ1] & cr[CR_C1_EN]) |
                     (cr[CR_IRQ2] & cr[CR_C2_EN] & ~cr[CR_C2_OUT]));

endmodule

// File: tb/tb_pia_port.sv
// Directed bench for pia_port: register access, C1/C2 flags, C2 output modes
// and reset, with expected values worked out by hand.
module tb_pia_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       rs;
    logic       rw;
    logic [7:0] dbin;
    logic [7:0] dbout;
    logic [7:0] pinin;
    logic [7:0] outreg;
    logic [7:0] ddr;
    logic       c1;
    logic       c2_in;
    logic       c2_out;
    logic       c2_oe;
    logic       irq_n;

    int n_vec = 0;
    int n_err = 0;

    pia_port dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .rs     (rs),
        .rw     (rw),
        .dbin   (dbin),
        .dbout  (dbout),
        .pinin  (pinin),
        .outreg (outreg),
        .ddr    (ddr),
        .c1     (c1),
        .c2_in  (c2_in),
        .c2_out (c2_out),
        .c2_oe  (c2_oe),
        .irq_n  (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic r, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; rs = r; dbin = d;
        tick(1);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_rd(input logic r);
        cs = 1'b1; rw = 1'b1; rs = r;
        tick(1);
        cs = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; rs = 1'b0; rw = 1'b1;
        dbin = 8'h00; pinin = 8'h00; c1 = 1'b1; c2_in = 1'b1;
        tick(2);
        chk("rst_outreg", outreg, 8'h00);
        chk("rst_ddr", ddr, 8'h00);
        chk("rst_dbout", dbout, 8'h00);
        chk("rst_c2_out", {7'd0, c2_out}, 8'h01);
        chk("rst_c2_oe", {7'd0, c2_oe}, 8'h00);
        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
        rst = 1'b0;
        tick(1);
        cpu_rd(1'b1);
        chk("rst_cr", dbout, 8'h00);

        // register file and mixed pin read
        pinin = 8'h3C;
        cpu_wr(1'b1, 8'h00);
        cpu_wr(1'b0, 8'hF0);
        cpu_wr(1'b1, 8'h04);
        cpu_wr(1'b0, 8'hA5);
        cpu_rd(1'b0);
        chk("ddr_val", ddr, 8'hF0);
        chk("or_val", outreg, 8'hA5);
        chk("or_read", dbout, 8'hAC);
        cpu_wr(1'b1, 8'h04);
        chk("dbout_hold", dbout, 8'hAC);

        // C1 rising edge with IRQ enabled, latency from pin change
        cpu_wr(1'b1, 8'h07);
        c1 = 1'b0;
        tick(4);
        chk("c1_fall_ignored", {7'd0, irq_n}, 8'h01);
        c1 = 1'b1;
        tick(2);
        chk("c1_irq_k1", {7'd0, irq_n}, 8'h01);
        tick(1);
        chk("c1_irq_k2", {7'd0, irq_n}, 8'h00);
        cpu_rd(1'b1);
        chk("cr_flag1", dbout, 8'h87);
        cpu_rd(1'b0);
        chk("or_rd_clr_irq", {7'd0, irq_n}, 8'h01);
        chk("or_rd_data", dbout, 8'hAC);
        cpu_rd(1'b1);
        chk("cr_cleared", dbout, 8'h07);

        // C1 falling edge with IRQ disabled
        cpu_wr(1'b1, 8'h04);
        c1 = 1'b0;
        tick(3);
        chk("c1_noen_irq_n", {7'd0, irq_n}, 8'h01);
        cpu_rd(1'b1);
        chk("cr_flag_noen", dbout, 8'h84);
        cpu_rd(1'b0);
        c1 = 1'b1;
        tick(4);
        cpu_rd(1'b1);
        chk("c1_rise_ignored", dbout, 8'h04);

        // handshake
        cpu_wr(1'b1, 8'h24);
        chk("hs_oe", {7'd0, c2_oe}, 8'h01);
        chk("hs_idle", {7'd0, c2_out}, 8'h01);
        cpu_rd(1'b0);
        chk("hs_k0", {7'd0, c2_out}, 8'h01);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("hs_low", {7'd0, c2_out}, 8'h00);
        end
        c1 = 1'b0;
        tick(3);
        chk("hs_before_c1", {7'd0, c2_out}, 8'h00);
        tick(1);
        chk("hs_c1_release", {7'd0, c2_out}, 8'h01);
        c1 = 1'b1;
        tick(4);

        // pulse, back-to-back pulse, manual modes, back to input mode
        cpu_wr(1'b1, 8'h2C);
        chk("pl_idle", {7'd0, c2_out}, 8'h01);
        cpu_rd(1'b0);
        chk("pl_k0", {7'd0, c2_out}, 8'h01);
        tick(1);
        chk("pl_k1", {7'd0, c2_out}, 8'h00);
        tick(1);
        chk("pl_k2", {7'd0, c2_out}, 8'h01);
        cpu_rd(1'b0);
        cpu_rd(1'b0);
        chk("pl2_first", {7'd0, c2_out}, 8'h00);
        tick(1);
        chk("pl2_held", {7'd0, c2_out}, 8'h00);
        tick(1);
        chk("pl2_end", {7'd0, c2_out}, 8'h01);
        cpu_wr(1'b1, 8'h3C);
        tick(1);
        chk("man_hi", {7'd0, c2_out}, 8'h01);
        cpu_wr(1'b1, 8'h34);
        tick(1);
        chk("man_lo", {7'd0, c2_out}, 8'h00);
        chk("man_lo_oe", {7'd0, c2_oe}, 8'h01);
        cpu_wr(1'b1, 8'h04);
        chk("in_oe", {7'd0, c2_oe}, 8'h00);
        tick(1);
        chk("in_force_hi", {7'd0, c2_out}, 8'h01);

        // C2 rising edge set colliding with an OR read clear
        cpu_wr(1'b1, 8'h1C);
        c2_in = 1'b0;
        tick(4);
        chk("c2_fall_ignored", {7'd0, irq_n}, 8'h01);
        c2_in = 1'b1;
        tick(2);
        cpu_rd(1'b0);
        chk("c2_set_wins_irq", {7'd0, irq_n}, 8'h00);
        chk("c2_or_data", dbout, 8'hAC);
        cpu_rd(1'b1);
        chk("c2_set_wins_cr", dbout, 8'h5C);

        // reset in the middle of a pulse
        cpu_wr(1'b1, 8'h2C);
        cpu_rd(1'b0);
        tick(1);
        chk("pre_rst_low", {7'd0, c2_out}, 8'h00);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_outreg", outreg, 8'h00);
        chk("mid_rst_ddr", ddr, 8'h00);
        chk("mid_rst_dbout", dbout, 8'h00);
        chk("mid_rst_c2_out", {7'd0, c2_out}, 8'h01);
        chk("mid_rst_c2_oe", {7'd0, c2_oe}, 8'h00);
        chk("mid_rst_irq_n", {7'd0, irq_n}, 8'h01);
        rst = 1'b0;
        tick(2);
        cpu_rd(1'b1);
        chk("post_rst_cr", dbout, 8'h00);
        chk("post_rst_c2_out", {7'd0, c2_out}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
